mul_32bit_seq: RTL

- Multi-cycle unsigned 32x32 -> 64 shift-add multiplier for the ALU datapath.
- Sits directly upstream of adder_32bit: it instantiates one adder_32bit and drives its a/b inputs every iteration. It consumes the adder's s/c outputs as the partial sum.
- Provides the MUL result path of the ALU behind a valid/ready handshake on both sides.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/adder_32bit.sv | 20 ++
 rtl/mul_32bit_seq.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared ALU definitions: datapath widths, multiplier iteration count,
// multiplier state encoding and the two's-complement magnitude helper used
// when the signed multiply option (MUL_SIGNED_EN) is built in.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_W     = 32;
    localparam int PROD_W    = 64;
    localparam int MUL_ITERS = 32;

    // NEG exists in every build so the encoding is identical with or
    // without the signed option.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } mul_state_t;

    // Absolute value of a two's-complement word. 32'h80000000 maps onto
    // itself, which read as unsigned is exactly 2^31.
    function automatic logic [ALU_W-1:0] magnitude(input logic [ALU_W-1:0] v);
        logic [ALU_W-1:0] r;
        if (v[ALU_W-1]) begin
            r = (~v) + 32'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_32bit.sv
// ---------------------------------------------------------------------------
// adder_32bit
// Combinational 32-bit unsigned adder with carry out.
// Ports:
//   a, b : 32-bit addends
//   s    : 32-bit sum
//   c    : carry out (bit 32 of the full sum)
// ---------------------------------------------------------------------------
import alu_pkg::*;

module adder_32bit (
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    output logic [ALU_W-1:0] s,
    output logic             c
);

    assign {c, s} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/mul_32bit_seq.sv
// ---------------------------------------------------------------------------
// mul_32bit_seq
// Multi-cycle unsigned 32x32 -> 64 shift-add multiplier. One adder_32bit is
// reused for all 32 iterations: each RUN cycle adds the multiplicand into the
// upper accumulator when the current multiplier bit is set, then shifts the
// 65-bit {carry, sum, lo} right by one.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operands a/b valid         in_ready   block can accept operands
//   a, b       multiplicand / multiplier
//   out_valid  product p valid             out_ready  consumer accepts p
//   p          64-bit product              busy       high in RUN, NEG or DONE
//   sgn        (MUL_SIGNED_EN only) treat a/b as two's complement
//
// Optional build macro: MUL_SIGNED_EN adds the sgn port and a NEG cycle that
// negates the product, making latency 34 for every operation in that build.
// ---------------------------------------------------------------------------
import alu_pkg::*;

module mul_32bit_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
`ifdef MUL_SIGNED_EN
    ,
    input  logic               sgn
`endif
);

    // The adder datapath is fixed at 32 bits; refuse any other width.
    if (WIDTH != ALU_W) begin : g_width_check
        $error("mul_32bit_seq: WIDTH must be 32");
    end

    // The counter must be able to represent 0..WIDTH.
    if ((1 << CNT_W) <= WIDTH) begin : g_cnt_check
        $error("mul_32bit_seq: CNT_W too small for WIDTH");
    end

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MUL_ITERS - 1);

    mul_state_t          state_r;
    logic [ALU_W-1:0]    mcand_r;
    logic [ALU_W-1:0]    hi_r;
    logic [ALU_W-1:0]    lo_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                in_ready_r;
    logic                out_valid_r;
    logic                busy_r;
    logic [PROD_W-1:0]   p_r;

    logic [ALU_W-1:0]    add_b_s;
    logic [ALU_W-1:0]    sum_s;
    logic                carry_s;
    logic [PROD_W-1:0]   shifted_prod_s;
    logic [PROD_W-1:0]   neg_prod_s;
    logic [ALU_W-1:0]    load_a_s;
    logic [ALU_W-1:0]    load_b_s;
    logic                neg_s;

    // Partial-product select: add the multiplicand only when the multiplier
    // bit currently at lo[0] is set.
    always_comb begin
        if (lo_r[0]) begin
            add_b_s = mcand_r;
        end else begin
            add_b_s = {ALU_W{1'b0}};
        end
    end

    adder_32bit u_adder (
        .a (hi_r),
        .b (add_b_s),
        .s (sum_s),
        .c (carry_s)
    );

    // {hi, lo} after the current iteration's shift; the carry lands in hi[31].
    assign shifted_prod_s = {carry_s, sum_s, lo_r[ALU_W-1:1]};
    assign neg_prod_s     = (~{hi_r, lo_r}) + 64'd1;

`ifdef MUL_SIGNED_EN
    logic neg_r;
    logic neg_next_s;

    // Signed operands are loaded as magnitudes; the sign of the result is
    // remembered separately and applied in the NEG cycle.
    always_comb begin
        if (sgn) begin
            load_a_s   = magnitude(a);
            load_b_s   = magnitude(b);
            neg_next_s = a[WIDTH-1] ^ b[WIDTH-1];
        end else begin
            load_a_s   = a;
            load_b_s   = b;
            neg_next_s = 1'b0;
        end
    end

    assign neg_s = neg_r;
`else
    // Unsigned-only build: operands load unchanged, result never negated.
    always_comb begin
        load_a_s = a;
        load_b_s = b;
        neg_s    = 1'b0;
    end
`endif

    // Control FSM and datapath registers, all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            mcand_r     <= {ALU_W{1'b0}};
            hi_r        <= {ALU_W{1'b0}};
            lo_r        <= {ALU_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            p_r         <= {PROD_W{1'b0}};
`ifdef MUL_SIGNED_EN
            neg_r       <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        mcand_r    <= load_a_s;
                        hi_r       <= {ALU_W{1'b0}};
                        lo_r       <= load_b_s;
                        cnt_r      <= {CNT_W{1'b0}};
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= RUN;
`ifdef MUL_SIGNED_EN
                        neg_r      <= neg_next_s;
`endif
                    end
                end
                RUN: begin
                    hi_r  <= {carry_s, sum_s[ALU_W-1:1]};
                    lo_r  <= {sum_s[0], lo_r[ALU_W-1:1]};
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == LAST_ITER) begin
`ifdef MUL_SIGNED_EN
                        state_r     <= NEG;
`else
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                        p_r         <= shifted_prod_s;
`endif
                    end
                end
                NEG: begin
                    // Unreachable without MUL_SIGNED_EN; neg_s is then 0.
                    state_r     <= DONE;
                    out_valid_r <= 1'b1;
                    if (neg_s) begin
                        p_r <= neg_prod_s;
                    end else begin
                        p_r <= {hi_r, lo_r};
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign p         = p_r;

endmodule
